pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 68 ++++++
 rtl/pixel_writer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Screen geometry, pixel bus widths and pixel writer state type.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int PIX_COUNT = SCREEN_W * SCREEN_H;
   localparam int ADDR_W    = 19;
   localparam int COLOR_W   = 8;
   localparam int ENTRY_W   = ADDR_W + COLOR_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } writer_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Purpose  : Synchronous first-word-fall-through FIFO for pending pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == C_FULL_CNT);
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_writer
// Purpose  : Filters and queues generated pixels, writes them to the framebuffer.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_writer
   import gpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int SLACK = 2
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [ADDR_W-1:0]  address,
   input  logic               pixValid,
   input  logic [COLOR_W-1:0] color,
   input  logic               lineDone,
   output logic               stop,
   output logic [ADDR_W-1:0]  memAddr,
   output logic [COLOR_W-1:0] memData,
   output logic               memWrite,
   input  logic               memReady,
   output logic               frameDone,
   output logic               oobDrop,
   output logic               overflow
);

   localparam int              CNT_W       = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] C_STOP_LVL = CNT_W'(DEPTH - SLACK);
   localparam logic [ADDR_W-1:0] C_PIX_END = ADDR_W'(PIX_COUNT);

   writer_state_t      r_state;
   writer_state_t      w_next_state;
   logic [ADDR_W-1:0]  r_last_addr;
   logic               r_last_valid;
   logic               r_stop;
   logic               r_oob;
   logic               r_ovf;

   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic [ENTRY_W-1:0] w_head;
   logic               w_accepting;
   logic               w_in_range;
   logic               w_dup;
   logic               w_cand;
   logic               w_push;
   logic               w_pop;
   logic               w_frame_done;
   logic               w_state_stop;

   assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
   assign w_in_range  = (address < C_PIX_END);
   assign w_dup       = r_last_valid && (address == r_last_addr);
   assign w_cand      = pixValid && w_accepting && w_in_range && !w_dup;
   assign w_pop       = memWrite && memReady;
   assign w_push      = w_cand && (!w_full || w_pop);

   pixel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({address, color}),
      .dout  (w_head),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      w_next_state = r_state;
      w_frame_done = 1'b0;
      w_state_stop = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (lineDone) begin
               w_next_state = ST_DRAIN;
            end else if (w_push) begin
               w_next_state = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (lineDone) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_state_stop = 1'b1;
            // The last entry leaving this cycle also completes the line.
            if ((w_count == '0) || ((w_count == CNT_W'(1)) && w_pop)) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_stop = 1'b1;
            w_frame_done = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= ST_IDLE;
         r_last_addr  <= '0;
         r_last_valid <= 1'b0;
         r_stop       <= 1'b0;
         r_oob        <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_stop  <= (w_count >= C_STOP_LVL);
         if (r_state == ST_DONE) begin
            r_last_addr  <= '0;
            r_last_valid <= 1'b0;
         end else if (w_push) begin
            r_last_addr  <= address;
            r_last_valid <= 1'b1;
         end
         if (pixValid && w_accepting && !w_in_range) begin
            r_oob <= 1'b1;
         end
         if (w_cand && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign stop      = r_stop || w_state_stop;
   assign memWrite  = !w_empty;
   assign memAddr   = w_empty ? '0 : w_head[ENTRY_W-1:COLOR_W];
   assign memData   = w_empty ? '0 : w_head[COLOR_W-1:0];
   assign frameDone = w_frame_done;
   assign oobDrop   = r_oob;
   assign overflow  = r_ovf;

endmodule
`default_nettype wire
